// File: rtl/pulse_train_gen.sv
// Purpose: pulse-train generator; a start pulse launches pulse_num pulses of high_len high / low_len low on sig.
// Latency: sig rises on the clock edge that samples start; done strobes the cycle after the final low phase.
// Backpressure: none; start is accepted only in IDLE (not queued), stop aborts from any state.
//
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   start, stop                    launch / abort requests
//   high_len, low_len, pulse_num   train configuration, latched on an accepted start
//   sig, busy, done                registered waveform, train-active flag, end-of-train strobe
module pulse_train_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] pulse_num,
  output logic             sig,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W-1:0] num_q;

  // Zero lengths behave as one cycle, so the minimum waveform is 1 high / 1 low.
  logic [CNT_W-1:0] high_eff;
  logic [CNT_W-1:0] low_eff;
  assign high_eff = (high_len == '0) ? ONE : high_len;
  assign low_eff  = (low_len  == '0) ? ONE : low_len;

  // Pulse counter may wrap in continuous mode; it is only compared when num_q != 0.
  logic [CNT_W-1:0] pulse_nxt;
  logic             last_pulse;
  assign pulse_nxt  = pulse_cnt + ONE;
  assign last_pulse = (num_q != '0) && (pulse_nxt == num_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sig       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      high_q    <= '0;
      low_q     <= '0;
      num_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // stop in the same cycle as start suppresses the launch
          if (start && !stop) begin
            state     <= HIGH;
            sig       <= 1'b1;
            busy      <= 1'b1;
            phase_cnt <= high_eff - ONE;
            pulse_cnt <= '0;
            high_q    <= high_eff;
            low_q     <= low_eff;
            num_q     <= pulse_num;
          end
        end

        HIGH: begin
          if (stop) begin
            state <= IDLE;
            sig   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (phase_cnt == '0) begin
            state     <= LOW;
            sig       <= 1'b0;
            phase_cnt <= low_q - ONE;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end

        LOW: begin
          // stop takes priority, so a stop on the final cycle still gives a single done
          if (stop) begin
            state <= IDLE;
            sig   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (phase_cnt == '0) begin
            pulse_cnt <= pulse_nxt;
            if (last_pulse) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= HIGH;
              sig       <= 1'b1;
              phase_cnt <= high_q - ONE;
            end
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end

        default: begin
          state <= IDLE;
          sig   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed vector table, hand-written corner sequences,
// then random stimulus compared against a timeline model of the waveform.
module tb_pulse_train_gen;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] pulse_num;
  logic             sig;
  logic             busy;
  logic             done;

  pulse_train_gen #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .high_len  (high_len),
    .low_len   (low_len),
    .pulse_num (pulse_num),
    .sig       (sig),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Timeline model: a train is "k cycles old"; sig is high in the first H cycles
  // of every H+L period, and the train lasts N*(H+L) cycles unless N is zero.
  bit     m_act;
  bit     m_done;
  longint m_k;
  longint m_h;
  longint m_l;
  longint m_n;

  function automatic longint eff(input logic [CNT_W-1:0] v);
    return (v == 0) ? 64'd1 : longint'(v);
  endfunction

  task automatic model_step(input logic st, input logic sp, input logic [CNT_W-1:0] h,
                            input logic [CNT_W-1:0] l, input logic [CNT_W-1:0] n);
    m_done = 1'b0;
    if (m_act) begin
      if (sp) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end else begin
        m_k = m_k + 1;
        if (m_n != 0 && m_k > m_n * (m_h + m_l)) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (st && !sp) begin
      m_act = 1'b1;
      m_k   = 1;
      m_h   = eff(h);
      m_l   = eff(l);
      m_n   = longint'(n);
    end
  endtask

  function automatic logic m_sig();
    return m_act && (((m_k - 1) % (m_h + m_l)) < m_h);
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic tick(input logic st, input logic sp, input logic [CNT_W-1:0] h,
                      input logic [CNT_W-1:0] l, input logic [CNT_W-1:0] n);
    start     = st;
    stop      = sp;
    high_len  = h;
    low_len   = l;
    pulse_num = n;
    @(posedge clk);
    model_step(st, sp, h, l, n);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_sig"},  sig,  m_sig());
    chk({tag, "_busy"}, busy, m_act);
    chk({tag, "_done"}, done, m_done);
  endtask

  typedef struct {
    logic             st;
    logic             sp;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic [CNT_W-1:0] n;
    logic             es;
    logic             eb;
    logic             ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic sp, input int h, input int l,
                              input int n, input logic es, input logic eb, input logic ed);
    vec_t v;
    v.st = st; v.sp = sp;
    v.h  = CNT_W'(h); v.l = CNT_W'(l); v.n = CNT_W'(n);
    v.es = es; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    high_len = '0; low_len = '0; pulse_num = '0;
    m_act = 1'b0; m_done = 1'b0; m_k = 0; m_h = 1; m_l = 1; m_n = 0;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    chk("reset_sig", sig, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- directed table ----------------
    // Single pulse H=3 L=2 N=1: sig high cycles 1-3, low 4-5, done in cycle 6.
    tbl.push_back(mk(1, 0, 3, 2, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // Start+stop together in IDLE, and stop alone in IDLE: nothing happens.
    tbl.push_back(mk(1, 1, 3, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    // Zero lengths H=0 L=0 N=2 act as H=1 L=1: busy 4 cycles.
    tbl.push_back(mk(1, 0, 0, 0, 2, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // Train H=1 L=1 N=4 with restarts and config changes mid-train (ignored),
    // then a start in the done cycle (accepted): H=2 L=1 N=1.
    tbl.push_back(mk(1, 0, 1, 1, 4, 1, 1, 0));
    tbl.push_back(mk(1, 0, 9, 9, 9, 0, 1, 0));
    tbl.push_back(mk(0, 0, 7, 5, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2, 2, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 2, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    // Stop on the cycle that would end the train anyway: exactly one done.
    tbl.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // Stop during HIGH aborts with done.
    tbl.push_back(mk(1, 0, 4, 1, 3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      tick(tbl[i].st, tbl[i].sp, tbl[i].h, tbl[i].l, tbl[i].n);
      total++;
      if ({sig, busy, done} !== {tbl[i].es, tbl[i].eb, tbl[i].ed}) begin
        bad++;
        $display("FAIL vec%0d: sig/busy/done got=%b%b%b expected=%b%b%b",
                 i, sig, busy, done, tbl[i].es, tbl[i].eb, tbl[i].ed);
      end
    end

    // ---------------- reset mid-HIGH ----------------
    tick(1, 0, 5, 1, 1);
    tick(0, 0, 0, 0, 0);
    chk("pre_rst_sig", sig, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_sig", sig, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_done", done, 1'b0);
    m_act = 1'b0; m_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0, 0);
      chk("post_rst_no_done", done, 1'b0);
      chk_model("post_rst");
    end

    // ---------------- continuous mode then stop in LOW ----------------
    tick(1, 0, 2, 3, 0);
    chk_model("cont");
    for (int i = 0; i < 19; i++) begin
      tick(0, 0, 0, 0, 0);
      chk_model("cont");
    end
    for (int i = 0; i < 10 && !(m_act && !m_sig()); i++) begin
      tick(0, 0, 0, 0, 0);
      chk_model("cont_seek");
    end
    chk("cont_in_low_busy", busy, 1'b1);
    tick(0, 1, 0, 0, 0);
    chk("cont_stop_sig", sig, 1'b0);
    chk("cont_stop_busy", busy, 1'b0);
    chk("cont_stop_done", done, 1'b1);
    tick(0, 0, 0, 0, 0);
    chk("cont_stop_done_clr", done, 1'b0);

    // ---------------- random stimulus vs model ----------------
    for (int i = 0; i < 600; i++) begin
      logic             st;
      logic             sp;
      logic [CNT_W-1:0] h;
      logic [CNT_W-1:0] l;
      logic [CNT_W-1:0] n;
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 39) == 0);
      h  = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 30)) : CNT_W'($urandom_range(0, 3));
      l  = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 30)) : CNT_W'($urandom_range(0, 3));
      n  = CNT_W'($urandom_range(0, 4));
      tick(st, sp, h, l, n);
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
